// File: rtl/crc16_frame_checker.sv
//------------------------------------------------------------------------------
// crc16_frame_checker
// Strips and checks the two-byte CRC-16 FCS of each received frame.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module crc16_frame_checker #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [7:0]       d,
  input  logic             d_valid,
  input  logic             d_last,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             frame_done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             short_err,
  output logic [LEN_W-1:0] payload_len
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ONE  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] C_LEN_MAX = '1;

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_p0;
  logic [7:0]       r_p1;
  logic [15:0]      r_crc;
  logic [LEN_W-1:0] r_count;

  logic             w_load_p0;
  logic             w_load_p1;
  logic             w_fwd;
  logic             w_done_full;
  logic             w_done_short;
  logic [15:0]      w_crc_fin;
  logic             w_fcs_ok;
  logic [LEN_W-1:0] w_count_inc;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Serial bit order is LSB first, so the byte enters the MSB-first register reflected.
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {bitrev8(b), 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  assign w_crc_fin   = crc_upd(r_crc, r_p0);
  assign w_fcs_ok    = (r_p1 == ~bitrev8(w_crc_fin[15:8])) && (d == ~bitrev8(w_crc_fin[7:0]));
  assign w_count_inc = (r_count == C_LEN_MAX) ? r_count : r_count + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_state <= S_IDLE;
    else if (init) r_state <= S_IDLE;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load_p0    = 1'b0;
    w_load_p1    = 1'b0;
    w_fwd        = 1'b0;
    w_done_full  = 1'b0;
    w_done_short = 1'b0;
    if (d_valid) begin
      case (r_state)
        S_IDLE: begin
          if (d_last) w_done_short = 1'b1;
          else begin
            w_load_p0    = 1'b1;
            w_state_next = S_ONE;
          end
        end
        S_ONE: begin
          if (d_last) begin
            w_done_short = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_load_p1    = 1'b1;
            w_state_next = S_RUN;
          end
        end
        S_RUN: begin
          w_fwd = 1'b1;
          if (d_last) begin
            w_done_full  = 1'b1;
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || init) begin
      r_p0        <= 8'h00;
      r_p1        <= 8'h00;
      r_crc       <= 16'h0000;
      r_count     <= '0;
      out_data    <= 8'h00;
      out_valid   <= 1'b0;
      frame_done  <= 1'b0;
      crc_ok      <= 1'b0;
      crc_err     <= 1'b0;
      short_err   <= 1'b0;
      payload_len <= '0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (w_load_p0) r_p0 <= d;
      if (w_load_p1) r_p1 <= d;
      if (w_fwd) begin
        out_data  <= r_p0;
        out_valid <= 1'b1;
      end
      if (w_fwd && !w_done_full) begin
        r_crc   <= w_crc_fin;
        r_p0    <= r_p1;
        r_p1    <= d;
        r_count <= w_count_inc;
      end
      if (w_done_full) begin
        crc_ok      <= w_fcs_ok;
        crc_err     <= !w_fcs_ok;
        short_err   <= 1'b0;
        payload_len <= w_count_inc;
        frame_done  <= 1'b1;
        r_crc       <= 16'h0000;
        r_count     <= '0;
      end
      if (w_done_short) begin
        crc_ok      <= 1'b0;
        crc_err     <= 1'b0;
        short_err   <= 1'b1;
        payload_len <= '0;
        frame_done  <= 1'b1;
        r_crc       <= 16'h0000;
        r_count     <= '0;
      end
    end
  end

endmodule

`default_nettype wire
